// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard scoreboard that sits beside the D stage of the pipelined MIPS core.
//   It tracks in-flight register writers in NSTAGE downstream stages
//   (1 = E .. NSTAGE = W).
//   Each tracked entry holds {valid, destination, tnew}. The tnew field ages
//   (saturating decrement) every time the pipeline advances.
//   From these entries the block produces:
//     - a combinational D-stage stall, and
//     - per-source forwarding stage selects.
//
//   Optional feature: define HAZARD_STALL_CNT_EN to build a saturating
//   32-bit stall-cycle counter. Without it, stall_cnt is tied to zero.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   ext_stall  freeze the whole pipeline (entries hold, no ageing)
//   flush      invalidate all tracked entries and the D instruction
//   d_valid    D stage holds a real instruction
//   d_rs/d_rt  D source registers; d_use_* says whether each is read,
//              and d_tuse_* says how many cycles until it is needed
//   d_we       D instruction writes d_a3; d_tnew is its result latency
//              measured from E entry
//   stall      hold PC/F/D and inject a bubble into E
//   fwd_rs/rt  youngest matching producer stage, 0 = register file
//   stall_cnt  count of cycles with stall=1 (optional feature)
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int NSTAGE = 3,
  parameter int TW     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ext_stall,
  input  logic                          flush,
  input  logic                          d_valid,
  input  logic [REG_AW-1:0]             d_rs,
  input  logic [REG_AW-1:0]             d_rt,
  input  logic                          d_use_rs,
  input  logic                          d_use_rt,
  input  logic [TW-1:0]                 d_tuse_rs,
  input  logic [TW-1:0]                 d_tuse_rt,
  input  logic                          d_we,
  input  logic [REG_AW-1:0]             d_a3,
  input  logic [TW-1:0]                 d_tnew,
  output logic                          stall,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt,
  output logic [31:0]                   stall_cnt
);

  localparam int FW = $clog2(NSTAGE+1);

  // Tracked entries; index 1 is E, index NSTAGE is W.
  logic              v_reg    [1:NSTAGE];
  logic [REG_AW-1:0] a3_reg   [1:NSTAGE];
  logic [TW-1:0]     tnew_reg [1:NSTAGE];

  logic          rs_hit, rt_hit;
  logic [FW-1:0] rs_k, rt_k;
  logic [TW-1:0] rs_tnew, rt_tnew;
  logic          haz_rs, haz_rt;

  // Youngest-match search. The scan runs from the oldest stage down to E,
  // so the last hit written is the youngest producer.
  always_comb begin
    rs_hit  = 1'b0;
    rs_k    = '0;
    rs_tnew = '0;
    rt_hit  = 1'b0;
    rt_k    = '0;
    rt_tnew = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (v_reg[k] && (a3_reg[k] == d_rs) && (d_rs != '0)) begin
        rs_hit  = 1'b1;
        rs_k    = FW'(k);
        rs_tnew = tnew_reg[k];
      end
      if (v_reg[k] && (a3_reg[k] == d_rt) && (d_rt != '0)) begin
        rt_hit  = 1'b1;
        rt_k    = FW'(k);
        rt_tnew = tnew_reg[k];
      end
    end
  end

  // A hazard exists only when the youngest producer's result will not be
  // ready by the time the consumer needs it.
  assign haz_rs = d_valid && d_use_rs && rs_hit && (rs_tnew > d_tuse_rs);
  assign haz_rt = d_valid && d_use_rt && rt_hit && (rt_tnew > d_tuse_rt);
  assign stall  = haz_rs | haz_rt | ext_stall;

  // The forwarding select ignores tnew: a stalled consumer still sees the
  // stage it will eventually forward from.
  assign fwd_rs = d_use_rs ? rs_k : '0;
  assign fwd_rt = d_use_rt ? rt_k : '0;

  genvar gi;
  generate
    for (gi = 1; gi <= NSTAGE; gi++) begin : g_entry
      if (gi == 1) begin : g_head
        // E stage: accept the D instruction, or a bubble on a data hazard.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_reg[gi]    <= 1'b0;
            a3_reg[gi]   <= '0;
            tnew_reg[gi] <= '0;
          end else if (flush) begin
            v_reg[gi] <= 1'b0;
          end else if (!ext_stall) begin
            v_reg[gi]    <= d_valid && d_we && (d_a3 != '0) && !(haz_rs || haz_rt);
            a3_reg[gi]   <= d_a3;
            tnew_reg[gi] <= d_tnew;
          end
        end
      end else begin : g_body
        // Later stages: shift from the previous stage with tnew aged by one.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v_reg[gi]    <= 1'b0;
            a3_reg[gi]   <= '0;
            tnew_reg[gi] <= '0;
          end else if (flush) begin
            v_reg[gi] <= 1'b0;
          end else if (!ext_stall) begin
            v_reg[gi]    <= v_reg[gi-1];
            a3_reg[gi]   <= a3_reg[gi-1];
            tnew_reg[gi] <= (tnew_reg[gi-1] == '0) ? '0 : tnew_reg[gi-1] - TW'(1);
          end
        end
      end
    end
  endgenerate

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Saturating count of stalled cycles. Only reset clears it; flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
